// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - packs decoded RV64IM fields into 32-bit instruction words
// One raw input register stage feeding a circular output FIFO; unencodable requests queue as zero with err set.
module rv_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_func3,
  input  logic [6:0]       in_func7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;
  localparam logic [2:0] FMT_SH = 3'd6;

  logic             s1_valid_q;
  logic [2:0]       s1_fmt_q;
  logic [6:0]       s1_op_q;
  logic [2:0]       s1_f3_q;
  logic [6:0]       s1_f7_q;
  logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [31:0]      s1_imm_q;

  logic [31:0]      mem_instr_q [FIFO_DEPTH];
  logic             mem_err_q   [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

  logic [31:0]      enc_instr;
  logic             enc_err;
  logic [CW:0]      occupancy;
  logic             accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the stage-1 entry so a push is always guaranteed a free slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
  assign in_ready  = reset && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_instr_q[rptr_q] : 32'h0;
  assign out_err   = out_valid ? mem_err_q[rptr_q] : 1'b0;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    case (s1_fmt_q)
      FMT_R:  enc_instr = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I: begin
        enc_err   = (s1_imm_q[31:11] != {21{s1_imm_q[11]}});
        enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      FMT_S: begin
        enc_err   = (s1_imm_q[31:11] != {21{s1_imm_q[11]}});
        enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      end
      FMT_SB: begin
        enc_err   = (s1_imm_q[31:12] != {20{s1_imm_q[12]}}) || s1_imm_q[0];
        enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                     s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      end
      FMT_U: begin
        enc_err   = (s1_imm_q[11:0] != 12'h0);
        enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      end
      FMT_UJ: begin
        enc_err   = (s1_imm_q[31:20] != {12{s1_imm_q[20]}}) || s1_imm_q[0];
        enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, s1_op_q};
      end
      FMT_SH: begin
        enc_err   = (s1_imm_q[31:6] != 26'h0);
        enc_instr = {s1_f7_q[6:1], s1_imm_q[5:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      default: enc_err = 1'b1;
    endcase
    if (s1_op_q[1:0] != 2'b11) enc_err = 1'b1;
    if (enc_err) enc_instr = 32'h0;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= '0;
      s1_op_q    <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_fmt_q <= in_fmt;
        s1_op_q  <= in_opcode;
        s1_f3_q  <= in_func3;
        s1_f7_q  <= in_func7;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_imm_q <= in_imm;
      end
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
        if (mem_err_q[rptr_q]) err_cnt_q <= err_cnt_q + CNT_W'(1);
        else                   enc_cnt_q <= enc_cnt_q + CNT_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wptr_q] <= enc_instr;
      mem_err_q[wptr_q]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb/tb_rv_instr_encoder.sv - directed self-checking bench for rv_instr_encoder
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_func3 = '0;
  logic [6:0]  in_func7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [31:0] enc_count, err_count;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_enc = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        exp_err;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp,
                              input logic exp_err, input string name);
    vec_t v;
    v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp = exp; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_func3 = v.f3; in_func7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask

  task automatic send(input vec_t v, output bit ok);
    ok = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk); @(negedge clk);
        ok = 1'b1;
      end else @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] ins, output logic e, output bit ok);
    ok = 1'b0; ins = '0; e = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid) begin
        ins = out_instr; e = out_err;
        @(posedge clk); @(negedge clk);
        ok = 1'b1;
      end else @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  function automatic vec_t addi_k(input int rd, input int k);
    logic [31:0] imm;
    imm = 32'(k);
    return mk(3'd1, 7'h13, 3'd0, 7'd0, 5'(rd), 5'd0, 5'd0, imm,
              (imm << 20) | (32'(rd) << 7) | 32'h13, 1'b0, "addi_k");
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_instr !== 32'h0 || out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_word got %h/%b want 0/0", out_instr, out_err); end
    n_cmp++; if (enc_count !== 32'd0 || err_count !== 32'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", enc_count, err_count); end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_r_latency();
    bit ok; logic [31:0] ins; logic e;
    send(mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, "add"), ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL r_send_timeout got none want accept"); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL r_latency_early got %b want 0", out_valid); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL r_latency_valid got %b want 1", out_valid); end
    recv(ins, e, ok);
    n_cmp++; if (!ok || ins !== 32'h002081B3 || e !== 1'b0) begin n_fail++; $display("FAIL r_add got %h/%b want 002081b3/0", ins, e); end
    exp_enc++;
    n_cmp++; if (enc_count !== 32'(exp_enc)) begin n_fail++; $display("FAIL r_enc_count got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_vectors();
    vec_t v[$];
    bit ok; logic [31:0] ins; logic e;
    v.push_back(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, "addi_m1"));
    v.push_back(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0, "jal_2048"));
    v.push_back(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, "beq_m4"));
    v.push_back(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4094,     32'h7E208FE3, 1'b0, "beq_4094"));
    v.push_back(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096,     32'h0,        1'b1, "beq_4096"));
    v.push_back(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3,        32'h0,        1'b1, "beq_odd"));
    v.push_back(mk(3'd2, 7'h23, 3'd3, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE20BC23, 1'b0, "sd_m8"));
    v.push_back(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, "lui"));
    v.push_back(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h0,        1'b1, "lui_low"));
    v.push_back(mk(3'd6, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd63,      32'h03F09093, 1'b0, "slli_63"));
    v.push_back(mk(3'd6, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd63,      32'h43F0D093, 1'b0, "srai_63"));
    v.push_back(mk(3'd6, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd64,      32'h0,        1'b1, "slli_64"));
    v.push_back(mk(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0,       32'h0,        1'b1, "fmt7"));
    v.push_back(mk(3'd0, 7'h30, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,       32'h0,        1'b1, "bad_opcode"));
    v.push_back(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,    32'h0,        1'b1, "addi_2048"));
    v.push_back(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0, "addi_m2048"));
    v.push_back(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF00000, 32'h800000EF, 1'b0, "jal_min"));
    v.push_back(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h0,        1'b1, "jal_over"));
    foreach (v[i]) begin
      send(v[i], ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_send_timeout got none want accept", v[i].name); end
      recv(ins, e, ok);
      n_cmp++;
      if (!ok || ins !== v[i].exp || e !== v[i].exp_err) begin
        n_fail++; $display("FAIL %s got %h/%b want %h/%b", v[i].name, ins, e, v[i].exp, v[i].exp_err);
      end
      if (v[i].exp_err) exp_err++; else exp_enc++;
    end
    n_cmp++; if (enc_count !== 32'(exp_enc)) begin n_fail++; $display("FAIL vec_enc_count got %0d want %0d", enc_count, exp_enc); end
    n_cmp++; if (err_count !== 32'(exp_err)) begin n_fail++; $display("FAIL vec_err_count got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    logic [31:0] held;
    bit a_now, p_now;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(addi_k(1, acc + 1));
      in_valid = (acc < 6);
      a_now = in_valid && in_ready;
      @(posedge clk); @(negedge clk);
      if (a_now) acc++;
    end
    n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== addi_k(1, 1).exp) begin n_fail++; $display("FAIL bp_head got %h want %h", out_instr, addi_k(1, 1).exp); end
    held = out_instr;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    n_cmp++; if (out_instr !== held) begin n_fail++; $display("FAIL bp_stable got %h want %h", out_instr, held); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid = (acc < 6);
      drive(addi_k(1, acc + 1));
      a_now = in_valid && in_ready;
      p_now = out_valid;
      if (p_now) begin
        n_cmp++;
        if (out_instr !== addi_k(1, got + 1).exp || out_err !== 1'b0) begin
          n_fail++; $display("FAIL bp_order_%0d got %h want %h", got, out_instr, addi_k(1, got + 1).exp);
        end
      end
      @(posedge clk); @(negedge clk);
      if (a_now) acc++;
      if (p_now) got++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL bp_drain got %0d want 6", got); end
    exp_enc += 6;
    n_cmp++; if (enc_count !== 32'(exp_enc)) begin n_fail++; $display("FAIL bp_enc_count got %0d want %0d", enc_count, exp_enc); end
  endtask

  task automatic test_streaming();
    int sent = 0, got = 0, first = -1, last = -1, stalls = 0;
    bit a_now, p_now;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 20; c++) begin
      in_valid = (sent < 20);
      drive(addi_k(2, sent + 100));
      if (in_valid && !in_ready) stalls++;
      a_now = in_valid && in_ready;
      p_now = out_valid;
      if (p_now) begin
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (out_instr !== addi_k(2, got + 100).exp) begin
          n_fail++; $display("FAIL stream_%0d got %h want %h", got, out_instr, addi_k(2, got + 100).exp);
        end
      end
      @(posedge clk); @(negedge clk);
      if (a_now) sent++;
      if (p_now) got++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got !== 20) begin n_fail++; $display("FAIL stream_count got %0d want 20", got); end
    n_cmp++; if (first !== 2) begin n_fail++; $display("FAIL stream_fill got %0d want 2", first); end
    n_cmp++; if (last - first + 1 !== 20) begin n_fail++; $display("FAIL stream_rate got %0d cycles want 20", last - first + 1); end
    n_cmp++; if (stalls !== 0) begin n_fail++; $display("FAIL stream_stalls got %0d want 0", stalls); end
    exp_enc += 20;
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] ins; logic e;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(addi_k(4, k + 7), ok);
    @(posedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued got %b want 1", out_valid); end
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hs got %b/%b want 0/0", out_valid, in_ready); end
    n_cmp++; if (enc_count !== 32'd0 || err_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_counters got %0d/%0d want 0/0", enc_count, err_count); end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    exp_enc = 0; exp_err = 0;
    send(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE3B7, 1'b0, "lui_x7"), ok);
    recv(ins, e, ok);
    n_cmp++; if (!ok || ins !== 32'hABCDE3B7 || e !== 1'b0) begin n_fail++; $display("FAIL mid_post got %h/%b want abcde3b7/0", ins, e); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %b want 0", out_valid); end
    n_cmp++; if (enc_count !== 32'd1 || err_count !== 32'd0) begin n_fail++; $display("FAIL mid_counters got %0d/%0d want 1/0", enc_count, err_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_latency();
    test_vectors();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
